// File: rtl/serial_paralelo_rx.sv
// Serial lane deserializer: COM (8'hBC) alignment, lock after BC_COUNT COMs, data byte delivery.
// Optional RX_LOSS_DETECT_EN drops lock after more than MAX_DATA_RUN data bytes without a COM.
module serial_paralelo_rx #(
  parameter logic [7:0]  COM_SYM      = 8'hBC,
  parameter int unsigned BC_COUNT     = 4,
  parameter int unsigned MAX_DATA_RUN = 16
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic       byte_strobe
);

  generate
    if (BC_COUNT < 2 || BC_COUNT > 15 ||
        MAX_DATA_RUN < 1 || MAX_DATA_RUN > 255) begin : g_bad_param
      $error("serial_paralelo_rx: parameter out of range");
    end
  endgenerate

  typedef enum logic [1:0] {
    SEARCH   = 2'd0,
    ALIGNING = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] com_cnt_q, com_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       active_q, active_d;
  logic       strobe_q, strobe_d;
  logic [7:0] nb;
  logic       boundary;
  logic       is_com;
`ifdef RX_LOSS_DETECT_EN
  logic [7:0] run_q, run_d;
`endif

  assign nb       = {sr_q[6:0], data_in};
  assign boundary = (bit_cnt_q == 3'd7);
  assign is_com   = (nb == COM_SYM);

  always_comb begin
    state_d   = state_q;
    sr_d      = nb;
    bit_cnt_d = bit_cnt_q + 3'd1;
    com_cnt_d = com_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    active_d  = active_q;
    strobe_d  = 1'b0;
`ifdef RX_LOSS_DETECT_EN
    run_d     = run_q;
`endif
    unique case (state_q)
      SEARCH: begin
        data_d   = 8'h00;
        valid_d  = 1'b0;
        active_d = 1'b0;
        if (is_com) begin
          bit_cnt_d = 3'd0;
          com_cnt_d = 4'd1;
          state_d   = ALIGNING;
        end
      end
      ALIGNING: begin
        data_d  = 8'h00;
        valid_d = 1'b0;
        if (boundary) begin
          strobe_d = 1'b1;
          if (is_com) begin
            com_cnt_d = com_cnt_q + 4'd1;
            if (com_cnt_q + 4'd1 == BC_COUNT[3:0]) begin
              state_d  = LOCKED;
              active_d = 1'b1;
`ifdef RX_LOSS_DETECT_EN
              run_d    = 8'd0;
`endif
            end
          end else begin
            com_cnt_d = 4'd0;
            state_d   = SEARCH;
          end
        end
      end
      LOCKED: begin
        if (boundary) begin
          strobe_d = 1'b1;
          if (is_com) begin
            valid_d = 1'b0;
`ifdef RX_LOSS_DETECT_EN
            run_d   = 8'd0;
`endif
          end else begin
            data_d  = nb;
            valid_d = 1'b1;
`ifdef RX_LOSS_DETECT_EN
            run_d   = run_q + 8'd1;
            // this byte would exceed the run limit: discard it and relink
            if (run_q == MAX_DATA_RUN[7:0]) begin
              state_d   = SEARCH;
              active_d  = 1'b0;
              valid_d   = 1'b0;
              data_d    = 8'h00;
              com_cnt_d = 4'd0;
              run_d     = 8'd0;
            end
`endif
          end
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk_8f) begin
    if (reset) begin
      state_q   <= SEARCH;
      sr_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
      com_cnt_q <= 4'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
      strobe_q  <= 1'b0;
`ifdef RX_LOSS_DETECT_EN
      run_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      active_q  <= active_d;
      strobe_q  <= strobe_d;
`ifdef RX_LOSS_DETECT_EN
      run_q     <= run_d;
`endif
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign active      = active_q;
  assign byte_strobe = strobe_q;

endmodule
